sdram_burst_master: RTL

- Initiator that drives the host-side register/buffer interface of the SDRAM MAC. Takes one burst command at a time from a client.
- Write commands: streams client words into the MAC write buffer, programs the address and length, then waits for completion.
- Read commands: programs the MAC, waits for completion, then drains the MAC read buffer to the client over a back-pressured stream.
- Sits between a DMA/client engine and the MAC, replacing CPU-driven register pokes.

---
 rtl/sdram_burst_master.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sdram_burst_master.sv
// Burst initiator for the SDRAM MAC host interface: fills/drains the MAC buffer
// and programs address, length and go for one client command at a time.
module sdram_burst_master #(
    parameter int MAX_WORDS = 255,
    parameter int RD_LAT    = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [23:0] cmd_addr_i,
    input  logic [7:0]  cmd_words_i,
    input  logic        wr_valid_i,
    output logic        wr_ready_o,
    input  logic [31:0] wr_data_i,
    output logic        rd_valid_o,
    input  logic        rd_ready_i,
    output logic [31:0] rd_data_o,
    output logic        done_o,
    output logic        err_o,
    output logic [7:0]  m_addr_o,
    output logic [31:0] m_wd_o,
    input  logic [31:0] m_rd_i,
    output logic        m_we_o,
    output logic        m_we_len_o,
    output logic        m_we_a_o,
    input  logic        m_busy_i
);

    localparam int DEPTH = RD_LAT + 1;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_SET_A, S_SET_LEN, S_ARM, S_RUN, S_DRAIN, S_FIN
    } state_t;

    state_t        state_q;
    logic          w_q;
    logic [23:0]   a_q;
    logic [7:0]    n_q;
    logic [7:0]    cnt_q;
    logic [7:0]    out_q;
    logic          err_q;
    logic [CW-1:0] inflight_q;
    logic [CW-1:0] count_q;
    logic [RD_LAT-1:0] pipe_q;
    logic [31:0]   fifo_q [DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;

    logic          accept;
    logic          illegal;
    logic          wr_fire;
    logic          push;
    logic          pop;
    logic          issue;
    logic [CW:0]   occ;

    assign cmd_ready_o = (state_q == S_IDLE) & ~m_busy_i & ~reset_i;
    assign accept      = cmd_valid_i & cmd_ready_o;
    assign illegal     = (cmd_words_i == 8'd0) || (32'(cmd_words_i) > MAX_WORDS);
    assign wr_ready_o  = (state_q == S_FILL);
    assign wr_fire     = wr_valid_i & wr_ready_o;
    assign rd_valid_o  = (count_q != '0);
    assign rd_data_o   = fifo_q[rptr_q];
    assign pop         = rd_valid_o & rd_ready_i;
    assign push        = pipe_q[RD_LAT-1];
    // Occupancy after this cycle's pop, so a slot freed now can be refilled now.
    assign occ   = {1'b0, count_q} + {1'b0, inflight_q} - (CW + 1)'(pop);
    assign issue = (state_q == S_DRAIN) && (cnt_q != n_q) && (occ < DEPTH_V);

    assign m_we_o     = wr_fire;
    assign m_we_a_o   = (state_q == S_SET_A);
    assign m_we_len_o = (state_q == S_SET_LEN);
    assign done_o     = (state_q == S_FIN);
    assign err_o      = err_q;

    always_comb begin
        m_addr_o = 8'd0;
        m_wd_o   = 32'd0;
        case (state_q)
            S_FILL: begin
                m_addr_o = cnt_q;
                m_wd_o   = wr_data_i;
            end
            S_SET_A:   m_wd_o = {8'h0, a_q};
            S_SET_LEN: m_wd_o = {w_q, 22'h0, n_q, 1'b0};
            S_DRAIN:   m_addr_o = cnt_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            w_q        <= 1'b0;
            a_q        <= '0;
            n_q        <= '0;
            cnt_q      <= '0;
            out_q      <= '0;
            err_q      <= 1'b0;
            inflight_q <= '0;
            count_q    <= '0;
            pipe_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            err_q      <= 1'b0;
            pipe_q     <= (pipe_q << 1) | RD_LAT'(issue);
            inflight_q <= inflight_q + CW'(issue) - CW'(push);
            count_q    <= count_q + CW'(push) - CW'(pop);
            if (push) begin
                fifo_q[wptr_q] <= m_rd_i;
                wptr_q <= (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
            end
            if (pop) rptr_q <= (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;

            case (state_q)
                S_IDLE: if (accept) begin
                    w_q   <= cmd_write_i;
                    a_q   <= cmd_addr_i;
                    n_q   <= cmd_words_i;
                    cnt_q <= '0;
                    out_q <= '0;
                    if (illegal) err_q <= 1'b1;
                    else state_q <= cmd_write_i ? S_FILL : S_SET_A;
                end
                S_FILL: if (wr_fire) begin
                    cnt_q <= cnt_q + 8'd1;
                    if (cnt_q == n_q - 8'd1) begin
                        cnt_q   <= '0;
                        state_q <= S_SET_A;
                    end
                end
                S_SET_A:   state_q <= S_SET_LEN;
                S_SET_LEN: state_q <= S_ARM;
                S_ARM:     if (m_busy_i) state_q <= S_RUN;
                S_RUN: if (!m_busy_i) begin
                    cnt_q   <= '0;
                    state_q <= w_q ? S_FIN : S_DRAIN;
                end
                S_DRAIN: begin
                    if (issue) cnt_q <= cnt_q + 8'd1;
                    if (pop) begin
                        out_q <= out_q + 8'd1;
                        if (out_q == n_q - 8'd1) state_q <= S_FIN;
                    end
                end
                S_FIN:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
